// File: rtl/ula_pkg.sv
// Shared ULA definitions: opcode encodings, datapath width and the
// multiply sequencer state type.
package ula_pkg;

  localparam int XLEN = 64;

  localparam logic [2:0] ULA_ADD = 3'b000;
  localparam logic [2:0] ULA_SUB = 3'b001;
  localparam logic [2:0] ULA_SLT = 3'b101;
  localparam logic [2:0] ULA_SLL = 3'b110;
  localparam logic [2:0] ULA_SRL = 3'b111;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    STEP  = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } mul_state_t;

endpackage

// File: rtl/ula_operand_mux.sv
// Chooses who drives the shared ULA: the multiply sequencer (sel=1)
// or the EX stage (sel=0). Purely combinational.
module ula_operand_mux #(
  parameter int XLEN = 64
) (
  input  logic            sel,
  input  logic [XLEN-1:0] seq_operand1,
  input  logic [XLEN-1:0] seq_operand2,
  input  logic [2:0]      seq_src,
  input  logic [XLEN-1:0] ex_operand1,
  input  logic [XLEN-1:0] ex_operand2,
  input  logic [2:0]      ex_src,
  output logic [XLEN-1:0] ula_operand1,
  output logic [XLEN-1:0] ula_operand2,
  output logic [2:0]      ula_src
);

  assign ula_operand1 = sel ? seq_operand1 : ex_operand1;
  assign ula_operand2 = sel ? seq_operand2 : ex_operand2;
  assign ula_src      = sel ? seq_src      : ex_src;

endmodule

// File: rtl/ula_mul_sequencer.sv
// Shift-add RV64 MUL controller that borrows the shared ULA for its add
// and shift-left steps, stalling EX (busy) until the product is consumed.
module ula_mul_sequencer
  import ula_pkg::*;
#(
  parameter int XLEN       = ula_pkg::XLEN,
  parameter int EARLY_EXIT = 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            flush,
  input  logic            start_valid,
  output logic            start_ready,
  input  logic [XLEN-1:0] start_a,
  input  logic [XLEN-1:0] start_b,
  output logic            result_valid,
  input  logic            result_ready,
  output logic [XLEN-1:0] result,
  output logic            busy,
  input  logic [XLEN-1:0] ex_operand1,
  input  logic [XLEN-1:0] ex_operand2,
  input  logic [2:0]      ex_ula_src,
  output logic [XLEN-1:0] ula_operand1,
  output logic [XLEN-1:0] ula_operand2,
  output logic [2:0]      ula_src,
  input  logic [XLEN-1:0] ula_result
);

  localparam int CNT_W = $clog2(XLEN + 1);

  mul_state_t      state;
  mul_state_t      state_next;
  logic [XLEN-1:0] mcand;
  logic [XLEN-1:0] mplier;
  logic [XLEN-1:0] prod;
  logic [CNT_W-1:0] cnt;

  logic            accept;
  logic            load_prod;
  logic            do_shift;
  logic            finish;
  logic            seq_sel;
  logic [XLEN-1:0] seq_operand1;
  logic [XLEN-1:0] seq_operand2;
  logic [2:0]      seq_src;

  assign finish = (EARLY_EXIT != 0) ? (mplier == '0) : (cnt == CNT_W'(XLEN));

  always_comb begin
    state_next   = state;
    accept       = 1'b0;
    load_prod    = 1'b0;
    do_shift     = 1'b0;
    seq_operand1 = prod;
    seq_operand2 = mcand;
    seq_src      = ULA_ADD;
    case (state)
      IDLE: begin
        if (start_valid && !flush) begin
          accept     = 1'b1;
          state_next = STEP;
        end
      end
      STEP: begin
        if (finish) begin
          state_next = DONE;
        end else if (mplier[0]) begin
          load_prod  = 1'b1;
          state_next = SHIFT;
        end else begin
          seq_operand1 = mcand;
          seq_operand2 = XLEN'(1);
          seq_src      = ULA_SLL;
          do_shift     = 1'b1;
        end
      end
      SHIFT: begin
        seq_operand1 = mcand;
        seq_operand2 = XLEN'(1);
        seq_src      = ULA_SLL;
        do_shift     = 1'b1;
        state_next   = STEP;
      end
      DONE: begin
        if (result_ready && !flush) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
    // Pipeline abort overrides every transition, including accept and handoff.
    if (flush) state_next = IDLE;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      mcand  <= '0;
      mplier <= '0;
      prod   <= '0;
      cnt    <= '0;
    end else begin
      state <= state_next;
      if (accept) begin
        mcand  <= start_a;
        mplier <= start_b;
        prod   <= '0;
        cnt    <= '0;
      end else begin
        if (load_prod) prod <= ula_result;
        if (do_shift) begin
          mcand  <= ula_result;
          mplier <= mplier >> 1;
          cnt    <= cnt + 1'b1;
        end
      end
    end
  end

  assign seq_sel      = (state == STEP) || (state == SHIFT);
  assign busy         = (state != IDLE);
  assign start_ready  = (state == IDLE) && !flush;
  assign result_valid = (state == DONE) && !flush;
  assign result       = prod;

  ula_operand_mux #(
    .XLEN(XLEN)
  ) u_mux (
    .sel          (seq_sel),
    .seq_operand1 (seq_operand1),
    .seq_operand2 (seq_operand2),
    .seq_src      (seq_src),
    .ex_operand1  (ex_operand1),
    .ex_operand2  (ex_operand2),
    .ex_src       (ex_ula_src),
    .ula_operand1 (ula_operand1),
    .ula_operand2 (ula_operand2),
    .ula_src      (ula_src)
  );

endmodule

// File: tb/tb_ula_mul_sequencer.sv
// Bench for ula_mul_sequencer: transaction-level model (product = a*b,
// latency from bit counts) compared every cycle, plus directed literals.
module tb_ula_mul_sequencer;
  import ula_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        flush, start_valid, start_ready, result_valid, result_ready, busy;
  logic [63:0] start_a, start_b, result;
  logic [63:0] ex_operand1, ex_operand2, ula_operand1, ula_operand2, ula_result;
  logic [2:0]  ex_ula_src, ula_src;

  logic        e_start_valid, e_start_ready, e_result_valid, e_result_ready, e_busy;
  logic [63:0] e_a, e_b, e_result, e_ex1, e_ex2, e_op1, e_op2, e_ula_result;
  logic [2:0]  e_ex_src, e_src;

  int checks = 0;
  int failures = 0;
  bit rnd_en = 1'b0;
  logic [2:0] srcs [8];

  always #5 clk = ~clk;

  function automatic logic [63:0] ula_model(input logic [63:0] x, input logic [63:0] y,
                                            input logic [2:0] src);
    case (src)
      ULA_SLL: return x << y[5:0];
      ULA_SRL: return x >> y[5:0];
      ULA_SUB: return x - y;
      ULA_SLT: return {63'd0, ($signed(x) < $signed(y))};
      default: return x + y;
    endcase
  endfunction

  always_comb ula_result   = ula_model(ula_operand1, ula_operand2, ula_src);
  always_comb e_ula_result = ula_model(e_op1, e_op2, e_src);

  ula_mul_sequencer #(.XLEN(64), .EARLY_EXIT(1)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .start_valid(start_valid), .start_ready(start_ready),
    .start_a(start_a), .start_b(start_b),
    .result_valid(result_valid), .result_ready(result_ready), .result(result),
    .busy(busy),
    .ex_operand1(ex_operand1), .ex_operand2(ex_operand2), .ex_ula_src(ex_ula_src),
    .ula_operand1(ula_operand1), .ula_operand2(ula_operand2), .ula_src(ula_src),
    .ula_result(ula_result)
  );

  ula_mul_sequencer #(.XLEN(64), .EARLY_EXIT(0)) dut_full (
    .clk(clk), .reset(reset), .flush(flush),
    .start_valid(e_start_valid), .start_ready(e_start_ready),
    .start_a(e_a), .start_b(e_b),
    .result_valid(e_result_valid), .result_ready(e_result_ready), .result(e_result),
    .busy(e_busy),
    .ex_operand1(e_ex1), .ex_operand2(e_ex2), .ex_ula_src(e_ex_src),
    .ula_operand1(e_op1), .ula_operand2(e_op2), .ula_src(e_src),
    .ula_result(e_ula_result)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  function automatic int exp_lat(input logic [63:0] b, input bit early);
    int msb = -1;
    int pop = 0;
    for (int i = 0; i < 64; i++) if (b[i]) begin msb = i; pop++; end
    return early ? (msb + 1) + pop + 1 : 64 + pop + 1;
  endfunction

  // Transaction model of the EARLY_EXIT=1 instance.
  typedef enum {M_IDLE, M_RUN, M_DONE} mphase_t;
  mphase_t     m_phase = M_IDLE;
  int          m_rem = 0;
  int          m_acc = 0;
  logic [63:0] m_prod = '0;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_phase <= M_IDLE;
      m_rem   <= 0;
      m_prod  <= '0;
    end else if (flush) begin
      m_phase <= M_IDLE;
    end else begin
      case (m_phase)
        M_IDLE: if (start_valid) begin
          m_prod  <= start_a * start_b;
          m_rem   <= exp_lat(start_b, 1'b1);
          m_phase <= M_RUN;
          m_acc   <= m_acc + 1;
        end
        M_RUN: begin
          m_rem <= m_rem - 1;
          if (m_rem == 1) m_phase <= M_DONE;
        end
        M_DONE: if (result_ready) m_phase <= M_IDLE;
        default: m_phase <= M_IDLE;
      endcase
    end
  end

  always @(negedge clk) begin
    if (!reset) begin
      chk("busy", busy, m_phase != M_IDLE);
      chk("start_ready", start_ready, (m_phase == M_IDLE) && !flush);
      chk("result_valid", result_valid, (m_phase == M_DONE) && !flush);
      if (m_phase == M_DONE && !flush) chk("result", result, m_prod);
      if (m_phase != M_RUN) begin
        chk("pass_op1", ula_operand1, ex_operand1);
        chk("pass_op2", ula_operand2, ex_operand2);
        chk("pass_src", ula_src, ex_ula_src);
      end else begin
        chk("run_src_legal", (ula_src == ULA_ADD) || (ula_src == ULA_SLL), 1);
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk); #1;
      if (rnd_en) begin
        flush        = ($urandom_range(0, 39) == 0);
        result_ready = ($urandom_range(0, 3) != 0);
        ex_operand1  = {$urandom, $urandom};
        ex_operand2  = {$urandom, $urandom};
        ex_ula_src   = 3'($urandom_range(0, 7));
      end
    end
  end

  task automatic run_dir(input logic [63:0] a, input logic [63:0] b, input int lat,
                         input logic [63:0] res, input string name);
    int n = 0;
    @(posedge clk); #1;
    start_a = a; start_b = b; start_valid = 1'b1;
    @(posedge clk); #1;
    start_valid = 1'b0;
    while (!result_valid && n < 300) begin
      if (n < 8) srcs[n] = ula_src;
      @(posedge clk); #1;
      n++;
    end
    chk({name, "_lat"}, n, lat);
    chk({name, "_res"}, result, res);
    if (result_ready) begin @(posedge clk); #1; end
  endtask

  task automatic run_full(input logic [63:0] a, input logic [63:0] b, input int lat,
                          input logic [63:0] res, input string name);
    int n = 0;
    @(posedge clk); #1;
    e_a = a; e_b = b; e_start_valid = 1'b1;
    @(posedge clk); #1;
    e_start_valid = 1'b0;
    while (!e_result_valid && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    chk({name, "_lat"}, n, lat);
    chk({name, "_res"}, e_result, res);
    @(posedge clk); #1;
    chk({name, "_idle"}, e_busy, 0);
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; start_valid = 1'b0; result_ready = 1'b1;
    start_a = '0; start_b = '0;
    ex_operand1 = '0; ex_operand2 = '0; ex_ula_src = '0;
    e_start_valid = 1'b0; e_result_ready = 1'b1; e_a = '0; e_b = '0;
    e_ex1 = '0; e_ex2 = '0; e_ex_src = '0;
    repeat (2) @(posedge clk); #1;
    chk("reset_result", result, 0);
    chk("reset_valid", result_valid, 0);
    chk("reset_busy", busy, 0);
    reset = 1'b0;

    ex_operand1 = 64'd7; ex_operand2 = 64'd9; ex_ula_src = 3'b001;
    #1;
    chk("idle_op1", ula_operand1, 64'd7);
    chk("idle_op2", ula_operand2, 64'd9);
    chk("idle_src", ula_src, 3'b001);
    chk("idle_ready", start_ready, 1);
    chk("idle_busy", busy, 0);

    run_dir(64'd3, 64'd5, 6, 64'd15, "mul3x5");
    chk("seq0_add", srcs[0], ULA_ADD);
    chk("seq1_sll", srcs[1], ULA_SLL);
    chk("seq2_sll", srcs[2], ULA_SLL);
    chk("seq3_add", srcs[3], ULA_ADD);
    chk("seq4_sll", srcs[4], ULA_SLL);
    run_dir(64'h1234, 64'd0, 1, 64'd0, "b_zero");
    run_dir('1, '1, 129, 64'd1, "all_ones");
    run_dir(64'h8000_0000_0000_0000, 64'd2, 4, 64'd0, "wrap");

    run_full(64'h1234, 64'd0, 65, 64'd0, "full_b_zero");
    for (int i = 0; i < 3; i++) begin
      logic [63:0] ra, rb;
      ra = {$urandom, $urandom};
      rb = {$urandom, $urandom} >> $urandom_range(0, 63);
      run_full(ra, rb, exp_lat(rb, 1'b0), ra * rb, "full_rand");
    end

    result_ready = 1'b0;
    run_dir(64'd5, 64'd7, 7, 64'd35, "bp");
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      chk("bp_hold_res", result, 64'd35);
      chk("bp_hold_valid", result_valid, 1);
      chk("bp_no_ready", start_ready, 0);
    end
    result_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_release", busy, 0);

    @(posedge clk); #1;
    start_a = 64'd9; start_b = 64'd1; start_valid = 1'b1;
    @(posedge clk); #1;
    start_valid = 1'b0;
    @(posedge clk); #1;
    chk("flush_in_shift", ula_src, ULA_SLL);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    chk("flush_idle", busy, 0);
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      chk("flush_no_valid", result_valid, 0);
    end

    run_dir(64'd2, 64'd3, 5, 64'd6, "after_flush");

    @(posedge clk); #1;
    start_a = '1; start_b = '1; start_valid = 1'b1;
    @(posedge clk); #1;
    start_valid = 1'b0;
    repeat (5) @(posedge clk);
    #2 reset = 1'b1;
    #1;
    chk("areset_result", result, 0);
    chk("areset_valid", result_valid, 0);
    chk("areset_busy", busy, 0);
    #1 reset = 1'b0;
    @(posedge clk); #1;
    flush = 1'b1; start_valid = 1'b1; start_a = 64'd4; start_b = 64'd4;
    @(posedge clk); #1;
    chk("flush_blocks_start", busy, 0);
    flush = 1'b0; start_valid = 1'b0;

    rnd_en = 1'b1;
    for (int t = 0; t < 40; t++) begin
      int acc0, w;
      @(posedge clk); #1;
      start_a = {$urandom, $urandom};
      start_b = {$urandom, $urandom} >> $urandom_range(0, 63);
      start_valid = 1'b1;
      acc0 = m_acc;
      w = 0;
      while (m_acc == acc0 && w < 100) begin @(posedge clk); #1; w++; end
      chk("rnd_accept", m_acc != acc0, 1);
      start_valid = 1'b0;
      w = 0;
      while (m_phase != M_IDLE && w < 600) begin @(posedge clk); #1; w++; end
      chk("rnd_drain", m_phase == M_IDLE, 1);
    end
    rnd_en = 1'b0;
    flush = 1'b0; result_ready = 1'b1;
    repeat (3) @(posedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
